// File: rtl/gpio_pattern_gen.sv
// gpio_pattern_gen: prescaled pattern stimulus for GPIO_Board bring-up.
// Drives matrix rows, 7-segment digits and decimal points from an 8-bit phase
// that advances on prescaler ticks, or on single-step requests while paused.
// It also loops the switches back to the LEDs with their two halves swapped.
// Optional: define GPIO_PATTERN_GEN_DEBOUNCE_EN to add a synchroniser and a
// debounce stage on sw before the loopback.
module gpio_pattern_gen #(
    parameter int unsigned PRESCALE_W = 24,
    parameter int unsigned N_ROWS     = 8,
    parameter int unsigned ROW_W      = 16,
    parameter int unsigned N_DIGITS   = 8,
    parameter int unsigned SW_W       = 32,
    parameter int unsigned DEB_W      = 16
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [1:0]                mode,
    input  logic                      pause,
    input  logic                      step,
    output logic [N_ROWS*ROW_W-1:0]   rows,
    output logic [N_DIGITS*7-1:0]     hex_seg,
    output logic [N_DIGITS-1:0]       hex_dp,
    input  logic [SW_W-1:0]           sw,
    output logic [SW_W-1:0]           led,
    output logic [7:0]                phase
);

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_WALK    = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_e;

    localparam int unsigned HALF = SW_W / 2;

    logic [PRESCALE_W-1:0]    div_cnt_q, div_cnt_d;
    logic [7:0]               phase_q, phase_d;
    logic                     step_q, step_d;
    logic [N_ROWS*ROW_W-1:0]  rows_q, rows_d;
    logic [N_DIGITS*7-1:0]    hex_seg_q, hex_seg_d;
    logic [N_DIGITS-1:0]      hex_dp_q, hex_dp_d;
    logic [SW_W-1:0]          led_q, led_d;
    logic [SW_W-1:0]          swin;
    logic [ROW_W-1:0]         rep;
    logic                     tick, step_rise, adv;
    int unsigned              ph_row, ph_bit;
    mode_e                    mode_sel;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Prescaler tick, step edge detect and phase advance
    always_comb begin
        mode_sel  = mode_e'(mode);
        tick      = &div_cnt_q;
        step_rise = step & ~step_q;
        adv       = pause ? step_rise : tick;
        div_cnt_d = div_cnt_q + PRESCALE_W'(1);
        step_d    = step;
        phase_d   = adv ? phase_q + 8'd1 : phase_q;
    end

    // Pattern outputs decoded from the current phase and mode
    always_comb begin
        rows_d    = '0;
        hex_seg_d = '0;
        hex_dp_d  = '0;
        rep       = '0;
        ph_row    = 32'(phase_q) % N_ROWS;
        ph_bit    = 32'(phase_q) % ROW_W;
        for (int unsigned i = 0; i < ROW_W; i++) begin
            rep[i] = phase_q[i % 8];
        end
        for (int unsigned r = 0; r < N_ROWS; r++) begin
            for (int unsigned i = 0; i < ROW_W; i++) begin
                unique case (mode_sel)
                    // Upper half mirrors the lower half inverted: row N-1-r = ~row r
                    MODE_COUNT: begin
                        if (r < N_ROWS / 2)
                            rows_d[r*ROW_W + i] = rep[(i + ROW_W - (r % ROW_W)) % ROW_W];
                        else
                            rows_d[r*ROW_W + i] =
                                ~rep[(i + ROW_W - ((N_ROWS - 1 - r) % ROW_W)) % ROW_W];
                    end
                    MODE_CHASE:   rows_d[r*ROW_W + i] = (r == ph_row);
                    MODE_WALK:    rows_d[r*ROW_W + i] = (i == (ph_bit + r) % ROW_W);
                    MODE_CHECKER: rows_d[r*ROW_W + i] = (((r + 32'(phase_q[0]) + i) % 2) == 1);
                endcase
            end
        end
        for (int unsigned d = 0; d < N_DIGITS; d++) begin
            if (mode_sel == MODE_CHASE) begin
                for (int unsigned s = 0; s < 7; s++) begin
                    hex_seg_d[d*7 + s] = (((32'(phase_q) + d) % 7) == s);
                end
            end else begin
                hex_seg_d[d*7 +: 7] = hex_glyph(4'((32'(phase_q[3:0]) + d) % 16));
            end
            hex_dp_d[d] = phase_q[0] ^ ((d % 2) == 1);
        end
        led_d = {swin[HALF-1:0], swin[SW_W-1:HALF]};
    end

`ifdef GPIO_PATTERN_GEN_DEBOUNCE_EN
    logic [SW_W-1:0]  sync1_q, sync1_d, sync2_q, sync2_d, swin_q, swin_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    // Counter runs only while the synchronised value is steady and differs from swin
    always_comb begin
        sync1_d   = sw;
        sync2_d   = sync1_q;
        swin_d    = swin_q;
        deb_cnt_d = deb_cnt_q;
        if ((sync1_q != sync2_q) || (sync2_q == swin_q)) begin
            deb_cnt_d = '0;
        end else if (&deb_cnt_q) begin
            swin_d    = sync2_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
        swin = swin_q;
    end

    // Synchroniser and debounce state
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            swin_q    <= '0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            swin_q    <= swin_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end
`else
    // Switches feed the loopback directly
    always_comb begin
        swin = sw;
    end
`endif

    // State and registered outputs; reset wins over any advance or loopback
    always_ff @(posedge clock) begin
        if (!resetn) begin
            div_cnt_q <= '0;
            phase_q   <= '0;
            step_q    <= 1'b0;
            rows_q    <= '0;
            hex_seg_q <= '0;
            hex_dp_q  <= '0;
            led_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            step_q    <= step_d;
            rows_q    <= rows_d;
            hex_seg_q <= hex_seg_d;
            hex_dp_q  <= hex_dp_d;
            led_q     <= led_d;
        end
    end

    assign rows    = rows_q;
    assign hex_seg = hex_seg_q;
    assign hex_dp  = hex_dp_q;
    assign led     = led_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Bench for gpio_pattern_gen with small parameters (4-bit prescaler, 4x8 rows,
// 4 digits, 8 switches). A reference model of the phase and outputs feeds a
// per-cycle scoreboard; hand-derived vectors and sequences cover the corners.
module tb_gpio_pattern_gen;

    logic        clock;
    logic        resetn;
    logic [1:0]  mode;
    logic        pause;
    logic        step;
    logic [31:0] rows;
    logic [27:0] hex_seg;
    logic [3:0]  hex_dp;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic [7:0]  phase;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_pattern_gen #(
        .PRESCALE_W(4),
        .N_ROWS    (4),
        .ROW_W     (8),
        .N_DIGITS  (4),
        .SW_W      (8),
        .DEB_W     (4)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .mode   (mode),
        .pause  (pause),
        .step   (step),
        .rows   (rows),
        .hex_seg(hex_seg),
        .hex_dp (hex_dp),
        .sw     (sw),
        .led    (led),
        .phase  (phase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        logic [31:0] rows;
        logic [27:0] hex;
        logic [3:0]  dp;
        logic [7:0]  led;
        logic [7:0]  phase;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  ph;
        logic [31:0] rows;
        logic [27:0] hex;
        logic [3:0]  dp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int sh);
        return (v << sh) | (v >> (8 - sh));
    endfunction

    function automatic logic [31:0] f_rows(input logic [1:0] md, input logic [7:0] ph);
        logic [7:0] r8 [4];
        for (int r = 0; r < 4; r++) begin
            case (md)
                2'd0:    r8[r] = (r < 2) ? rotl8(ph, r) : ~rotl8(ph, 3 - r);
                2'd1:    r8[r] = (int'(ph[1:0]) == r) ? 8'hFF : 8'h00;
                2'd2:    r8[r] = 8'h01 << ((int'(ph[2:0]) + r) % 8);
                default: r8[r] = (((r + int'(ph[0])) % 2) == 0) ? 8'hAA : 8'h55;
            endcase
        end
        return {r8[3], r8[2], r8[1], r8[0]};
    endfunction

    function automatic logic [27:0] f_hex(input logic [1:0] md, input logic [7:0] ph);
        logic [27:0] h;
        h = '0;
        for (int d = 0; d < 4; d++) begin
            if (md == 2'd1) h[d*7 +: 7] = 7'(1 << ((int'(ph) + d) % 7));
            else            h[d*7 +: 7] = GLYPH[(int'(ph[3:0]) + d) % 16];
        end
        return h;
    endfunction

    function automatic logic [3:0] f_dp(input logic [7:0] ph);
        logic [3:0] p;
        for (int d = 0; d < 4; d++) p[d] = ph[0] ^ ((d % 2) == 1);
        return p;
    endfunction

    function automatic exp_t mk_exp(input logic rn, input logic [1:0] md, input logic [7:0] ph,
                                    input logic a, input logic [7:0] s);
        exp_t e;
        if (!rn) begin
            e.rows = '0; e.hex = '0; e.dp = '0; e.led = '0; e.phase = '0;
        end else begin
            e.rows  = f_rows(md, ph);
            e.hex   = f_hex(md, ph);
            e.dp    = f_dp(ph);
            e.led   = {s[3:0], s[7:4]};
            e.phase = ph + {7'd0, a};
        end
        return e;
    endfunction

    // Reference model of prescaler / step / phase
    logic [3:0] m_div;
    logic [7:0] m_phase;
    logic       m_stepq;
    logic       m_adv;
    logic       sb_en = 1'b0;
    exp_t       sb_q [$];

    assign m_adv = pause ? (step & ~m_stepq) : (m_div == 4'hF);

    always @(posedge clock) begin
        if (sb_en) sb_q.push_back(mk_exp(resetn, mode, m_phase, m_adv, sw));
        if (!resetn) begin
            m_div   <= '0;
            m_phase <= '0;
            m_stepq <= 1'b0;
        end else begin
            m_div   <= m_div + 4'd1;
            m_stepq <= step;
            if (m_adv) m_phase <= m_phase + 8'd1;
        end
    end

    task automatic check_out(input exp_t e);
        check("sb_rows",  64'(rows),    64'(e.rows));
        check("sb_hex",   64'(hex_seg), 64'(e.hex));
        check("sb_dp",    64'(hex_dp),  64'(e.dp));
        check("sb_led",   64'(led),     64'(e.led));
        check("sb_phase", 64'(phase),   64'(e.phase));
    endtask

    always @(negedge clock) begin
        if (sb_q.size() != 0) check_out(sb_q.pop_front());
    end

    task automatic step_to(input logic [7:0] target);
        int n;
        n = 0;
        while (m_phase != target && n < 300) begin
            step = 1'b1;
            @(negedge clock);
            step = 1'b0;
            @(negedge clock);
            n++;
        end
        if (n >= 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL step_bound: phase %0h not reached, model at %0h", target, m_phase);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    vec_t vecs [8];

    initial begin
        int n;
        vecs[0] = '{2'd0, 8'h03, 32'hFCF90603, {7'h7D, 7'h6D, 7'h66, 7'h4F}, 4'b0101};
        vecs[1] = '{2'd1, 8'h05, 32'h0000FF00, {7'h02, 7'h01, 7'h40, 7'h20}, 4'b0101};
        vecs[2] = '{2'd1, 8'h06, 32'h00FF0000, {7'h04, 7'h02, 7'h01, 7'h40}, 4'b1010};
        vecs[3] = '{2'd2, 8'h0A, 32'h20100804, {7'h5E, 7'h39, 7'h7C, 7'h77}, 4'b1010};
        vecs[4] = '{2'd2, 8'h0F, 32'h04020180, {7'h5B, 7'h06, 7'h3F, 7'h71}, 4'b0101};
        vecs[5] = '{2'd3, 8'h37, 32'hAA55AA55, {7'h77, 7'h6F, 7'h7F, 7'h07}, 4'b0101};
        vecs[6] = '{2'd0, 8'h81, 32'h7EFC0381, {7'h66, 7'h4F, 7'h5B, 7'h06}, 4'b0101};
        vecs[7] = '{2'd0, 8'hFF, 32'h0000FFFF, {7'h5B, 7'h06, 7'h3F, 7'h71}, 4'b0101};

        resetn = 1'b0; mode = 2'd0; pause = 1'b0; step = 1'b0; sw = 8'hA5;
        sb_en = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_rows",  64'(rows),    64'h0);
        check("rst_hex",   64'(hex_seg), 64'h0);
        check("rst_dp",    64'(hex_dp),  64'h0);
        check("rst_led",   64'(led),     64'h0);
        check("rst_phase", 64'(phase),   64'h0);

        // Release: first tick 15 clocks later, phase 1 from clock 16, 2 from 32
        resetn = 1'b1;
        repeat (15) @(negedge clock);
        check("tick_pre", 64'(phase), 64'h0);
        @(negedge clock);
        check("tick_first", 64'(phase), 64'h1);
        repeat (15) @(negedge clock);
        check("tick2_pre", 64'(phase), 64'h1);
        @(negedge clock);
        check("tick_second", 64'(phase), 64'h2);

        // Loopback: one clock latency, halves swapped
        check("lb_a5", 64'(led), 64'h5A);
        sw = 8'h12;
        check("lb_hold", 64'(led), 64'h5A);
        @(negedge clock);
        check("lb_12", 64'(led), 64'h21);

        // Paused: three 1-clock pulses plus one long hold -> exactly 4 steps
        pause = 1'b1;
        repeat (3) begin
            step = 1'b1;
            @(negedge clock);
            step = 1'b0;
            repeat (2) @(negedge clock);
        end
        step = 1'b1;
        repeat (20) @(negedge clock);
        step = 1'b0;
        @(negedge clock);
        check("pause_step", 64'(phase), 64'h6);

        // Mode change keeps the phase
        mode = 2'd1;
        repeat (3) @(negedge clock);
        check("mode_keep_phase", 64'(phase), 64'h6);
        check("mode1_rows", 64'(rows), 64'h00FF0000);

        // Unpaused with step held: only ticks advance (48 clocks -> 3 ticks)
        step = 1'b1;
        pause = 1'b0;
        repeat (48) @(negedge clock);
        check("run_step_held", 64'(phase), 64'h9);

        // Step edge on the tick cycle gives a single increment
        step = 1'b0;
        n = 0;
        while (m_div != 4'hF && n < 20) begin
            @(negedge clock);
            n++;
        end
        step = 1'b1;
        @(negedge clock);
        check("tick_step_once", 64'(phase), 64'hA);
        step = 1'b0;
        pause = 1'b1;
        @(negedge clock);

        // Pattern vectors
        for (int i = 0; i < 8; i++) begin
            mode = vecs[i].mode;
            step_to(vecs[i].ph);
            repeat (2) @(negedge clock);
            check($sformatf("vec%0d_phase", i), 64'(phase),   64'(vecs[i].ph));
            check($sformatf("vec%0d_rows", i),  64'(rows),    64'(vecs[i].rows));
            check($sformatf("vec%0d_hex", i),   64'(hex_seg), 64'(vecs[i].hex));
            check($sformatf("vec%0d_dp", i),    64'(hex_dp),  64'(vecs[i].dp));
        end

        // Wrap 255 -> 0, then a full 256-tick lap
        pause = 1'b0;
        n = 0;
        while (phase == 8'hFF && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("wrap_ff_00", 64'(phase), 64'h0);
        repeat (4095) @(negedge clock);
        check("lap_pre", 64'(phase), 64'hFF);
        @(negedge clock);
        check("lap_wrap", 64'(phase), 64'h0);

        // Mid-run reset in checker mode at phase 0x37, with a step pending
        pause = 1'b1;
        mode = 2'd3;
        step_to(8'h37);
        repeat (2) @(negedge clock);
        check("pre_rst_rows",  64'(rows),  64'hAA55AA55);
        check("pre_rst_phase", 64'(phase), 64'h37);
        resetn = 1'b0;
        step = 1'b1;
        sw = 8'hFF;
        @(negedge clock);
        check("mrst_rows",  64'(rows),    64'h0);
        check("mrst_hex",   64'(hex_seg), 64'h0);
        check("mrst_dp",    64'(hex_dp),  64'h0);
        check("mrst_led",   64'(led),     64'h0);
        check("mrst_phase", 64'(phase),   64'h0);
        resetn = 1'b1;
        step = 1'b0;
        pause = 1'b0;
        repeat (15) @(negedge clock);
        check("mrst_tick_pre", 64'(phase), 64'h0);
        @(negedge clock);
        check("mrst_tick", 64'(phase), 64'h1);
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
